// File: rtl/serial_to_parallel_pkg.sv
// rtl/serial_to_parallel_pkg.sv - byte width, FSM encoding and timeout default shared with the serializer
package serial_to_parallel_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEFAULT_TIMEOUT = 1_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/serial_to_parallel_idle_timer.sv
// rtl/serial_to_parallel_idle_timer.sv - inter-byte idle counter with expiry strobe
module serial_to_parallel_idle_timer
    import serial_to_parallel_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // High on the cycle whose edge brings the count to TIMEOUT; the owner
    // leaves COLLECT on that edge, which clears the counter.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - assembles UART bytes MSB-first into an N-bit word with valid/ready output
module serial_to_parallel
    import serial_to_parallel_pkg::*;
#(
    parameter int N       = 32,
    parameter int CNT_W   = 3,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         iCE_CLK,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    input  logic         tx_ready,
    output logic [N-1:0] tx_bytes,
    output logic         tx_valid,
    output logic         busy,
    output logic         overrun,
    output logic         timeout
);

    localparam int               NBYTES   = N / BYTE_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [N-1:0]     shreg;
    logic             accept;
    logic             expired;
    logic             timer_clear;
    logic             tx_valid_d;
    logic             busy_d;
    logic             overrun_d;
    logic             timeout_d;

    always_ff @(posedge iCE_CLK) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            tx_valid <= tx_valid_d;
            busy     <= busy_d;
            overrun  <= overrun_d;
            timeout  <= timeout_d;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    accept     = 1'b1;
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (rx_valid) begin
                    accept = 1'b1;
                    if (count == LAST_CNT) state_next = ST_FULL;
                end else if (expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FULL: begin
                // A byte arriving on the consuming edge starts the next word.
                if (tx_ready) begin
                    accept     = rx_valid;
                    state_next = rx_valid ? ST_COLLECT : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid_d = (state_next == ST_FULL);
        busy_d     = (state_next == ST_COLLECT);
        overrun_d  = (state == ST_FULL) && rx_valid && !tx_ready;
        timeout_d  = (state == ST_COLLECT) && !rx_valid && expired;
    end

    always_ff @(posedge iCE_CLK) begin
        if (!rst_n) begin
            count <= '0;
            shreg <= '0;
        end else if (accept) begin
            count <= (state == ST_COLLECT) ? count + 1'b1 : CNT_W'(1);
            shreg <= {shreg[N-BYTE_W-1:0], rx_byte};
        end else if (state_next == ST_IDLE) begin
            count <= '0;
        end
    end

    assign tx_bytes    = shreg;
    assign timer_clear = accept || (state_next != state);

    serial_to_parallel_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (iCE_CLK),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (state == ST_COLLECT),
        .expired (expired)
    );

endmodule
